mlp_mac_sequencer: RTL and testbench

Upstream and downstream control stage for the combinational `mlp_xls` MAC/ReLU stage. It holds one layer's 4-bit weights and 4-bit input activations. For each neuron it streams one `(i, w)` pair per cycle into the MAC and owns the 16-bit accumulator register that feeds the MAC's `t` input. When a neuron's last pair has been accumulated, it emits the ReLU result over a valid/ready handshake.

---
 rtl/mlp_pkg.sv | 22 ++
 rtl/mlp_mac_sequencer_if.sv | 25 ++
 rtl/mlp_operand_store.sv | 79 +++++++
 rtl/mlp_mac_sequencer.sv | 138 +++++++++++++
 tb/tb_mlp_mac_sequencer.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mlp_pkg.sv
// Shared types and constants for the MLP MAC sequencer.
// Optional bias support is enabled with MLP_SEQ_BIAS_EN.
package mlp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    EMIT = 2'd2
  } seq_state_t;

  localparam logic [1:0] WR_SEL_WEIGHT = 2'd0;
  localparam logic [1:0] WR_SEL_INPUT  = 2'd1;
  localparam logic [1:0] WR_SEL_BIAS   = 2'd2;

  typedef logic [3:0]  nib_t;
  typedef logic [15:0] acc_t;

  function automatic acc_t sext16(input logic [7:0] v);
    return {{8{v[7]}}, v};
  endfunction

endpackage

// File: rtl/mlp_mac_sequencer_if.sv
// Result handshake between the MAC sequencer and its consumer.
// Master drives valid/data/index, slave drives ready.
interface mlp_mac_sequencer_if;
  import mlp_pkg::*;

  logic       y_valid;
  logic       y_ready;
  acc_t       y_data;
  logic [7:0] y_idx;

  modport master (
    output y_valid,
    output y_data,
    output y_idx,
    input  y_ready
  );

  modport slave (
    input  y_valid,
    input  y_data,
    input  y_idx,
    output y_ready
  );

endinterface

// File: rtl/mlp_operand_store.sv
// Weight/input (and, with MLP_SEQ_BIAS_EN, bias) register file.
// One write port, combinational reads indexed by neuron n and input k.
module mlp_operand_store
  import mlp_pkg::*;
#(
  parameter int N_IN  = 8,
  parameter int N_OUT = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       we,
  input  logic [1:0] sel,
  input  logic [7:0] addr,
  input  logic [7:0] data,
  input  logic [7:0] n,
  input  logic [7:0] k,
  input  logic [7:0] b_idx,
  output nib_t       x_rd,
  output nib_t       w_rd,
  output logic [7:0] b_rd
);

  localparam int NW = N_IN * N_OUT;
  localparam int AW = (NW > 1) ? $clog2(NW) : 1;
  localparam int KW = (N_IN > 1) ? $clog2(N_IN) : 1;

  nib_t        w_q [NW];
  nib_t        x_q [N_IN];
  logic        w_hit;
  logic        x_hit;
  logic [15:0] a16;
  logic [15:0] w_idx;

  assign a16   = 16'(addr);
  assign w_hit = we && (sel == WR_SEL_WEIGHT) && (32'(addr) < NW);
  assign x_hit = we && (sel == WR_SEL_INPUT) && (32'(addr) < N_IN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NW; i++) w_q[i] <= '0;
      for (int i = 0; i < N_IN; i++) x_q[i] <= '0;
    end else begin
      if (w_hit) w_q[a16[AW-1:0]] <= data[3:0];
      if (x_hit) x_q[addr[KW-1:0]] <= data[3:0];
    end
  end

  // Row-major weight layout: neuron n owns entries n*N_IN .. n*N_IN+N_IN-1
  assign w_idx = 16'(n) * 16'(N_IN) + 16'(k);
  assign w_rd  = w_q[w_idx[AW-1:0]];
  assign x_rd  = x_q[k[KW-1:0]];

`ifdef MLP_SEQ_BIAS_EN
  localparam int NB = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  logic [7:0] b_q [N_OUT];
  logic       b_hit;
  logic       unused_bi;

  assign b_hit     = we && (sel == WR_SEL_BIAS) && (32'(addr) < N_OUT);
  assign unused_bi = ^b_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_OUT; i++) b_q[i] <= '0;
    end else if (b_hit) begin
      b_q[addr[NB-1:0]] <= data;
    end
  end

  assign b_rd = b_q[b_idx[NB-1:0]];
`else
  logic unused_b;

  assign unused_b = ^{b_idx, data[7:4]};
  assign b_rd     = '0;
`endif

endmodule

// File: rtl/mlp_mac_sequencer.sv
// Streams (x, w) pairs into a combinational MAC, owns the accumulator
// and emits per-neuron ReLU results. Bias init via MLP_SEQ_BIAS_EN.
module mlp_mac_sequencer
  import mlp_pkg::*;
#(
  parameter int N_IN  = 8,
  parameter int N_OUT = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [1:0]                 wr_sel,
  input  logic [7:0]                 wr_addr,
  input  logic [7:0]                 wr_data,
  input  logic                       start,
  output logic                       busy,
  output nib_t                       mac_i,
  output nib_t                       mac_w,
  output acc_t                       mac_t,
  input  acc_t                       mac_total,
  input  acc_t                       mac_relu,
  mlp_mac_sequencer_if.master        yif,
  output logic                       done
);

  seq_state_t state_q, state_d;
  logic [7:0] n_q, k_q, y_idx_q;
  acc_t       acc_q, y_data_q, init_val;
  logic       done_q;
  nib_t       x_rd, w_rd;
  logic [7:0] b_rd, b_idx;
  logic       wr_ok, last_k, last_n;

  assign wr_ok  = wr_en && (state_q == IDLE);
  assign last_k = (k_q == 8'(N_IN - 1));
  assign last_n = (n_q == 8'(N_OUT - 1));
  assign b_idx  = (state_q == IDLE) ? 8'd0 : n_q + 8'd1;

  mlp_operand_store #(
    .N_IN  (N_IN),
    .N_OUT (N_OUT)
  ) u_store (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_ok),
    .sel   (wr_sel),
    .addr  (wr_addr),
    .data  (wr_data),
    .n     (n_q),
    .k     (k_q),
    .b_idx (b_idx),
    .x_rd  (x_rd),
    .w_rd  (w_rd),
    .b_rd  (b_rd)
  );

`ifdef MLP_SEQ_BIAS_EN
  logic [7:0] b_src;

  // A bias written on the start edge must already seed the accumulator
  assign b_src    = (wr_ok && (wr_sel == WR_SEL_BIAS) && (wr_addr == b_idx))
                  ? wr_data : b_rd;
  assign init_val = sext16(b_src);
`else
  logic unused_b;

  assign unused_b = ^b_rd;
  assign init_val = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last_k) state_d = EMIT;
      EMIT:    if (yif.y_ready) state_d = last_n ? IDLE : RUN;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_q      <= '0;
      k_q      <= '0;
      acc_q    <= '0;
      y_data_q <= '0;
      y_idx_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            n_q   <= '0;
            k_q   <= '0;
            acc_q <= init_val;
          end
        end
        RUN: begin
          acc_q <= mac_total;
          k_q   <= k_q + 8'd1;
          if (last_k) begin
            y_data_q <= mac_relu;
            y_idx_q  <= n_q;
          end
        end
        EMIT: begin
          if (yif.y_ready) begin
            k_q <= '0;
            if (last_n) begin
              n_q    <= '0;
              done_q <= 1'b1;
            end else begin
              n_q   <= n_q + 8'd1;
              acc_q <= init_val;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign mac_i       = (state_q == RUN) ? x_rd : '0;
  assign mac_w       = (state_q == RUN) ? w_rd : '0;
  assign mac_t       = acc_q;
  assign yif.y_valid = (state_q == EMIT);
  assign yif.y_data  = y_data_q;
  assign yif.y_idx   = y_idx_q;

endmodule

// File: tb/tb_mlp_mac_sequencer.sv
// Directed bench: small layer (2x2) and default layer (8x4) instances,
// each driven by a behavioural model of the combinational MAC.
`define CHK(tag, obs, exp) \
  begin \
    checks++; \
    assert ((obs) === (exp)) else begin \
      errors++; \
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp); \
    end \
  end

module tb_mlp_mac_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        rst_a, wr_en_a, start_a, busy_a, done_a;
  logic [1:0]  wr_sel_a;
  logic [7:0]  wr_addr_a, wr_data_a;
  logic [3:0]  mac_i_a, mac_w_a;
  logic [15:0] mac_t_a, tot_a, relu_a;

  logic        rst_b, wr_en_b, start_b, busy_b, done_b;
  logic [1:0]  wr_sel_b;
  logic [7:0]  wr_addr_b, wr_data_b;
  logic [3:0]  mac_i_b, mac_w_b;
  logic [15:0] mac_t_b, tot_b, relu_b;

  mlp_mac_sequencer_if ya();
  mlp_mac_sequencer_if yb();

  mlp_mac_sequencer #(.N_IN(2), .N_OUT(2)) dut_a (
    .clk(clk), .rst_n(rst_a), .wr_en(wr_en_a), .wr_sel(wr_sel_a),
    .wr_addr(wr_addr_a), .wr_data(wr_data_a), .start(start_a),
    .busy(busy_a), .mac_i(mac_i_a), .mac_w(mac_w_a), .mac_t(mac_t_a),
    .mac_total(tot_a), .mac_relu(relu_a), .yif(ya), .done(done_a)
  );

  mlp_mac_sequencer dut_b (
    .clk(clk), .rst_n(rst_b), .wr_en(wr_en_b), .wr_sel(wr_sel_b),
    .wr_addr(wr_addr_b), .wr_data(wr_data_b), .start(start_b),
    .busy(busy_b), .mac_i(mac_i_b), .mac_w(mac_w_b), .mac_t(mac_t_b),
    .mac_total(tot_b), .mac_relu(relu_b), .yif(yb), .done(done_b)
  );

  function automatic logic [31:0] mac_f(input logic [3:0] i, input logic [3:0] w,
                                        input logic [15:0] t);
    int si, sw, s;
    logic [15:0] tot;
    si  = $signed(i);
    sw  = $signed(w);
    s   = $signed({t[14], t[14:0]});
    s   = s + si * sw;
    tot = 16'(s);
    return {tot, tot[15] ? 16'h0000 : tot};
  endfunction

  always_comb {tot_a, relu_a} = mac_f(mac_i_a, mac_w_a, mac_t_a);
  always_comb {tot_b, relu_b} = mac_f(mac_i_b, mac_w_b, mac_t_b);

  task automatic wr_a(input logic [1:0] s, input logic [7:0] a, input logic [7:0] d);
    wr_en_a = 1'b1; wr_sel_a = s; wr_addr_a = a; wr_data_a = d;
    @(posedge clk); #1;
    wr_en_a = 1'b0;
  endtask

  task automatic wr_b(input logic [1:0] s, input logic [7:0] a, input logic [7:0] d);
    wr_en_b = 1'b1; wr_sel_b = s; wr_addr_b = a; wr_data_b = d;
    @(posedge clk); #1;
    wr_en_b = 1'b0;
  endtask

  task automatic load_basic_a();
    wr_a(2'd1, 8'd0, 8'h03);
    wr_a(2'd1, 8'd1, 8'h0E);
    wr_a(2'd0, 8'd0, 8'h02);
    wr_a(2'd0, 8'd1, 8'h05);
    wr_a(2'd0, 8'd2, 8'h0F);
    wr_a(2'd0, 8'd3, 8'h0C);
  endtask

  task automatic run_a(input int stall, input logic [15:0] e0,
                       input logic [15:0] e1, input logic [15:0] et0,
                       input bit illegal);
    logic [15:0] ex [2];
    int t;
    ex[0] = e0;
    ex[1] = e1;
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    if (illegal) begin
      start_a = 1'b1; wr_en_a = 1'b1; wr_sel_a = 2'd1;
      wr_addr_a = 8'd0; wr_data_a = 8'h07;
      @(posedge clk); #1;
      @(posedge clk); #1;
      start_a = 1'b0; wr_en_a = 1'b0;
    end
    for (int j = 0; j < 2; j++) begin
      t = 0;
      while (!ya.y_valid && t < 40) begin
        @(posedge clk); #1;
        t++;
      end
      checks++;
      if (ya.y_valid !== 1'b1) begin
        errors++;
        $error("FAIL a_valid_wait: no y_valid after %0d cycles", t);
      end
      `CHK("a_y_data", ya.y_data, ex[j])
      `CHK("a_y_idx", ya.y_idx, 8'(j))
      if (stall > 0 && j == 0) begin
        ya.y_ready = 1'b0;
        repeat (stall) begin
          @(posedge clk); #1;
          `CHK("bp_valid", ya.y_valid, 1'b1)
          `CHK("bp_data", ya.y_data, ex[0])
          `CHK("bp_mac_t", mac_t_a, et0)
          `CHK("bp_mac_i", mac_i_a, 4'h0)
        end
        ya.y_ready = 1'b1;
      end
      @(posedge clk); #1;
    end
    `CHK("a_done", done_a, 1'b1)
    `CHK("a_busy_end", busy_a, 1'b0)
  endtask

  initial begin
    int t;
    rst_a = 1'b0; wr_en_a = 1'b0; wr_sel_a = '0; wr_addr_a = '0;
    wr_data_a = '0; start_a = 1'b0; ya.y_ready = 1'b1;
    rst_b = 1'b0; wr_en_b = 1'b0; wr_sel_b = '0; wr_addr_b = '0;
    wr_data_b = '0; start_b = 1'b0; yb.y_ready = 1'b1;
    #3;
    checks++;
    if (busy_a !== 1'b0) begin
      errors++;
      $error("FAIL rst_busy: observed %0h expected 0", busy_a);
    end
    checks++;
    if (ya.y_valid !== 1'b0) begin
      errors++;
      $error("FAIL rst_valid: observed %0h expected 0", ya.y_valid);
    end
    `CHK("rst_data", ya.y_data, 16'h0000)
    `CHK("rst_idx", ya.y_idx, 8'h00)
    `CHK("rst_done", done_a, 1'b0)
    `CHK("rst_mac_i", mac_i_a, 4'h0)
    `CHK("rst_mac_w", mac_w_a, 4'h0)
    `CHK("rst_mac_t", mac_t_a, 16'h0000)
    @(posedge clk); #1;
    rst_a = 1'b1; rst_b = 1'b1;
    @(posedge clk); #1;

    load_basic_a();
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    `CHK("b_busy", busy_a, 1'b1)
    `CHK("b_mac_i0", mac_i_a, 4'h3)
    `CHK("b_mac_w0", mac_w_a, 4'h2)
    `CHK("b_mac_t0", mac_t_a, 16'h0000)
    for (int c = 1; c <= 7; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin
        `CHK("b_mac_i1", mac_i_a, 4'hE)
        `CHK("b_mac_w1", mac_w_a, 4'h5)
        `CHK("b_mac_t1", mac_t_a, 16'h0006)
      end
      if (c == 2) begin
        `CHK("b_valid0", ya.y_valid, 1'b1)
        `CHK("b_data0", ya.y_data, 16'h0000)
        `CHK("b_idx0", ya.y_idx, 8'h00)
        `CHK("b_emit_mac_i", mac_i_a, 4'h0)
      end
      if (c == 3) `CHK("b_valid_drop", ya.y_valid, 1'b0)
      if (c == 5) begin
        `CHK("b_valid1", ya.y_valid, 1'b1)
        `CHK("b_data1", ya.y_data, 16'h0005)
        `CHK("b_idx1", ya.y_idx, 8'h01)
        `CHK("b_done_early", done_a, 1'b0)
      end
      if (c == 6) begin
        `CHK("b_done6", done_a, 1'b1)
        `CHK("b_busy6", busy_a, 1'b0)
      end
      if (c == 7) `CHK("b_done_pulse", done_a, 1'b0)
    end

    run_a(5, 16'h0000, 16'h0005, 16'hFFFC, 1'b0);
    run_a(0, 16'h0000, 16'h0005, 16'hFFFC, 1'b1);
    run_a(0, 16'h0000, 16'h0005, 16'hFFFC, 1'b0);

    wr_a(2'd2, 8'd0, 8'hFB);
    wr_a(2'd1, 8'd0, 8'h01);
    wr_a(2'd1, 8'd1, 8'h01);
    wr_a(2'd0, 8'd0, 8'h02);
    wr_a(2'd0, 8'd1, 8'h02);
    wr_a(2'd0, 8'd2, 8'h00);
    wr_a(2'd0, 8'd3, 8'h00);
`ifdef MLP_SEQ_BIAS_EN
    run_a(0, 16'h0000, 16'h0000, 16'hFFFF, 1'b0);
`else
    run_a(0, 16'h0004, 16'h0000, 16'h0004, 1'b0);
`endif

    load_basic_a();
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    @(posedge clk); #1;
    rst_a = 1'b0;
    #1;
    `CHK("mr_busy", busy_a, 1'b0)
    `CHK("mr_valid", ya.y_valid, 1'b0)
    `CHK("mr_mac_t", mac_t_a, 16'h0000)
    @(posedge clk); #1;
    rst_a = 1'b1;
    @(posedge clk); #1;
    run_a(0, 16'h0000, 16'h0000, 16'h0000, 1'b0);

    for (int k = 0; k < 8; k++) wr_b(2'd1, 8'(k), 8'h08);
    for (int w = 0; w < 32; w++) wr_b(2'd0, 8'(w), 8'h08);
    start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
    for (int j = 0; j < 4; j++) begin
      t = 0;
      while (!yb.y_valid && t < 40) begin
        @(posedge clk); #1;
        t++;
      end
      checks++;
      if (yb.y_valid !== 1'b1) begin
        errors++;
        $error("FAIL x_valid_wait: no y_valid after %0d cycles", t);
      end
      `CHK("x_data", yb.y_data, 16'h0200)
      `CHK("x_idx", yb.y_idx, 8'(j))
      `CHK("x_mac_t", mac_t_b, 16'h0200)
      @(posedge clk); #1;
    end
    `CHK("x_done", done_b, 1'b1)
    `CHK("x_busy", busy_b, 1'b0)

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
